// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-counter Ising array: oscillator reset window,
// timed free-run, spin capture and weight-write gating.
module ising_run_ctrl #(
    parameter int N_SPINS    = 8,
    parameter int RST_CYCLES = 4,
    parameter int LEN_W      = 24
) (
    input  logic               clk,
    input  logic               axi_rstn,
    input  logic               wready,
    input  logic [1:0]         ctrl_sel,
    input  logic               ctrl_hit,
    input  logic [31:0]        wdata,
    input  logic [1:0]         rd_sel,
    output logic [31:0]        rdata,
    input  logic               weight_hit,
    output logic               weight_wr_en,
    output logic               ising_rstn_o,
    input  logic [N_SPINS-1:0] spin_in,
    output logic               busy,
    output logic               done_irq
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARST   = 2'd1,
        S_RUN    = 2'd2,
        S_SAMPLE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
    logic [LEN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [LEN_W-1:0]   run_len_q, run_len_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               werr_q, werr_d;
    logic               busy_q, busy_d;
    logic               irq_q, irq_d;
    logic               arst_q, arst_d;

    logic ctrl_wr, len_wr, start, abort, clr, idle;

    assign ctrl_wr = wready & ctrl_hit & (ctrl_sel == 2'd0);
    assign len_wr  = wready & ctrl_hit & (ctrl_sel == 2'd1);
    assign start   = ctrl_wr & wdata[0];
    assign abort   = ctrl_wr & wdata[1];
    assign clr     = ctrl_wr & wdata[2];
    assign idle    = (state_q == S_IDLE);

    assign weight_wr_en = wready & weight_hit & idle;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        run_cnt_d = run_cnt_q;
        run_len_d = run_len_q;
        result_d  = result_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        werr_d    = werr_q;
        irq_d     = 1'b0;

        if (clr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            werr_d    = 1'b0;
        end

        // ABORT overrides every state action, including a SAMPLE capture
        if (abort && !idle) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d   = S_ARST;
                        rst_cnt_d = RW'(RST_CYCLES - 1);
                        done_d    = 1'b0;
                    end
                end
                S_ARST: begin
                    if (rst_cnt_q == '0) begin
                        state_d   = S_RUN;
                        run_cnt_d = run_len_q;
                    end else begin
                        rst_cnt_d = rst_cnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == '0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        run_cnt_d = run_cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    result_d = 32'(spin_in);
                    done_d   = 1'b1;
                    irq_d    = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (len_wr) begin
            if (idle) begin
                run_len_d = wdata[LEN_W-1:0];
            end else begin
                werr_d = 1'b1;
            end
        end

        if (wready && weight_hit && !idle) begin
            werr_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        arst_d = (state_d == S_RUN) || (state_d == S_SAMPLE);
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            run_cnt_q <= '0;
            run_len_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            werr_q    <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
            arst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            run_cnt_q <= run_cnt_d;
            run_len_q <= run_len_d;
            result_q  <= result_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            werr_q    <= werr_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
            arst_q    <= arst_d;
        end
    end

    assign busy         = busy_q;
    assign done_irq     = irq_q;
    assign ising_rstn_o = arst_q;

    always_comb begin
        rdata = 32'd0;
        unique case (rd_sel)
            2'd0: rdata = {26'd0, state_q, werr_q, aborted_q, done_q, busy_q};
            2'd1: rdata = 32'(run_len_q);
            2'd2: rdata = result_q;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed self-checking bench for ising_run_ctrl with default parameters.
module tb_ising_run_ctrl;

    logic        clk = 1'b0;
    logic        axi_rstn;
    logic        wready;
    logic [1:0]  ctrl_sel;
    logic        ctrl_hit;
    logic [31:0] wdata;
    logic [1:0]  rd_sel;
    logic [31:0] rdata;
    logic        weight_hit;
    logic        weight_wr_en;
    logic        ising_rstn_o;
    logic [7:0]  spin_in;
    logic        busy;
    logic        done_irq;

    int checks = 0;
    int errors = 0;

    ising_run_ctrl #(.N_SPINS(8), .RST_CYCLES(4), .LEN_W(24)) dut (
        .clk          (clk),
        .axi_rstn     (axi_rstn),
        .wready       (wready),
        .ctrl_sel     (ctrl_sel),
        .ctrl_hit     (ctrl_hit),
        .wdata        (wdata),
        .rd_sel       (rd_sel),
        .rdata        (rdata),
        .weight_hit   (weight_hit),
        .weight_wr_en (weight_wr_en),
        .ising_rstn_o (ising_rstn_o),
        .spin_in      (spin_in),
        .busy         (busy),
        .done_irq     (done_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] s, output logic [31:0] v);
        rd_sel = s;
        #1;
        v = rdata;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        wready   = 1'b1;
        ctrl_hit = 1'b1;
        ctrl_sel = sel;
        wdata    = d;
        @(posedge clk);
        #1;
        wready   = 1'b0;
        ctrl_hit = 1'b0;
        wdata    = 32'd0;
    endtask

    task automatic wr_weight(input string tag, input logic exp_en);
        @(negedge clk);
        wready     = 1'b1;
        weight_hit = 1'b1;
        #1;
        check(tag, 32'(weight_wr_en), 32'(exp_en));
        @(posedge clk);
        #1;
        wready     = 1'b0;
        weight_hit = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        axi_rstn   = 1'b0;
        wready     = 1'b0;
        ctrl_sel   = 2'd0;
        ctrl_hit   = 1'b0;
        wdata      = 32'd0;
        rd_sel     = 2'd0;
        weight_hit = 1'b0;
        spin_in    = 8'hA5;
        step(2);

        check("rst_rstn", 32'(ising_rstn_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(done_irq), 32'd0);
        @(negedge clk);
        axi_rstn = 1'b1;
        step(1);
        rd(2'd0, v); check("rst_status", v, 32'h0);
        rd(2'd1, v); check("rst_runlen", v, 32'h0);
        rd(2'd2, v); check("rst_result", v, 32'h0);

        // basic run: RUN_LEN=10, START at edge k
        wr(2'd1, 32'd10);
        rd(2'd1, v); check("runlen_wr", v, 32'd10);
        wr(2'd0, 32'h1);
        rd(2'd0, v); check("basic_st_c1", v, 32'h11);
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("basic_rstn_c%0d", c), 32'(ising_rstn_o),
                  (c >= 5 && c <= 16) ? 32'd1 : 32'd0);
            check($sformatf("basic_irq_c%0d", c), 32'(done_irq),
                  (c == 17) ? 32'd1 : 32'd0);
            if (c == 16) begin
                rd(2'd0, v); check("basic_st_sample", v, 32'h31);
            end
            step(1);
        end
        rd(2'd2, v); check("basic_result", v, 32'hA5);
        rd(2'd0, v); check("basic_status", v, 32'h2);

        // RUN_LEN=0 with DONE already set
        spin_in = 8'h3C;
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        rd(2'd0, v); check("len0_st_c1", v, 32'h11);
        step(4);
        rd(2'd0, v); check("len0_st_c5", v, 32'h21);
        check("len0_rstn_c5", 32'(ising_rstn_o), 32'd1);
        step(1);
        rd(2'd0, v); check("len0_st_c6", v, 32'h31);
        step(1);
        check("len0_irq_c7", 32'(done_irq), 32'd1);
        rd(2'd0, v); check("len0_st_c7", v, 32'h2);
        rd(2'd2, v); check("len0_result", v, 32'h3C);

        // ABORT during RUN
        spin_in = 8'hFF;
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        step(5);
        rd(2'd0, v); check("abort_pre", v, 32'h21);
        wr(2'd0, 32'h2);
        rd(2'd0, v); check("abort_st", v, 32'h4);
        check("abort_rstn", 32'(ising_rstn_o), 32'd0);
        check("abort_irq", 32'(done_irq), 32'd0);
        for (int c = 0; c < 15; c++) begin
            if (done_irq) check("abort_late_irq", 32'(done_irq), 32'd0);
            step(1);
        end
        rd(2'd0, v); check("abort_st_late", v, 32'h4);
        rd(2'd2, v); check("abort_result", v, 32'h3C);
        wr(2'd0, 32'h3);
        rd(2'd0, v); check("start_abort_idle", v, 32'h4);
        step(1);
        check("start_abort_busy", 32'(busy), 32'd0);

        // writes while busy, repeated START, CLR
        wr(2'd0, 32'h4);
        rd(2'd0, v); check("clr_st", v, 32'h0);
        wr(2'd0, 32'h1);
        wr_weight("wgt_busy_en", 1'b0);
        wr(2'd1, 32'd5);
        rd(2'd1, v); check("busy_runlen", v, 32'd10);
        rd(2'd0, v); check("werr_st_c3", v, 32'h19);
        step(3);
        wr(2'd0, 32'h1);
        rd(2'd0, v); check("restart_st_c7", v, 32'h29);
        check("restart_rstn", 32'(ising_rstn_o), 32'd1);
        step(9);
        check("restart_irq_c16", 32'(done_irq), 32'd0);
        step(1);
        check("restart_irq_c17", 32'(done_irq), 32'd1);
        rd(2'd0, v); check("restart_st", v, 32'hA);
        wr(2'd0, 32'h4);
        rd(2'd0, v); check("clr_werr", v, 32'h0);
        wr_weight("wgt_idle_en", 1'b1);

        // async reset mid ARRAY_RST
        wr(2'd0, 32'h1);
        step(1);
        rd(2'd0, v); check("arst_pre", v, 32'h11);
        axi_rstn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rstn", 32'(ising_rstn_o), 32'd0);
        rd(2'd0, v); check("arst_status", v, 32'h0);
        rd(2'd1, v); check("arst_runlen", v, 32'h0);
        rd(2'd2, v); check("arst_result", v, 32'h0);
        @(negedge clk);
        axi_rstn = 1'b1;
        step(1);

        spin_in = 8'h5A;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step(3);
        check("post_rstn_c4", 32'(ising_rstn_o), 32'd0);
        step(1);
        check("post_rstn_c5", 32'(ising_rstn_o), 32'd1);
        step(3);
        rd(2'd0, v); check("post_st_c8", v, 32'h31);
        step(1);
        check("post_irq_c9", 32'(done_irq), 32'd1);
        rd(2'd2, v); check("post_result", v, 32'h5A);
        step(1);
        check("post_irq_c10", 32'(done_irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
